// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner arbiter driving a shared bit-select mux
// Grants one requester at a time, rotating on release or when the burst limit is hit under contention.
module mux_rr_arbiter #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 5,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    req,
  output logic [WIDTH-1:0]    grant,
  output logic [CHANNELS-1:0] select,
  output logic                gnt_valid,
  output logic                preempt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]    BURST = CW'(MAX_BURST);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_d;
  logic [CHANNELS-1:0] ptr_q, ptr_d;
  logic [CHANNELS-1:0] select_q, select_d;
  logic [WIDTH-1:0]    grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic                preempt_q, preempt_d;

  logic [CHANNELS-1:0] after_owner;
  logic                owner_req;
  logic                others_req;
  logic [CHANNELS:0]   pick_ptr, pick_rel, pick_rot;

  // Returns {found, index}: first set bit of mask walking circularly from start.
  function automatic logic [CHANNELS:0] pick(input logic [CHANNELS-1:0] start,
                                             input logic [WIDTH-1:0] mask);
    logic [CHANNELS:0] res;
    int                idx;
    res = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (mask[idx[IW-1:0]]) res = {1'b1, CHANNELS'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CHANNELS-1:0] inc_wrap(input logic [CHANNELS-1:0] o);
    if (int'(o) >= WIDTH - 1) return '0;
    return o + 1'b1;
  endfunction

  always_comb begin
    after_owner = inc_wrap(select_q);
    owner_req   = |(req & grant_q);
    others_req  = |(req & ~grant_q);
    pick_ptr    = pick(ptr_q, req);
    pick_rel    = pick(after_owner, req);
    pick_rot    = pick(after_owner, req & ~grant_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      select_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      select_q    <= select_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = GRANT;
      GRANT:   if (!owner_req && !others_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    select_d    = select_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    gnt_valid_d = gnt_valid_q;
    preempt_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_ptr[CHANNELS]) begin
          select_d    = pick_ptr[CHANNELS-1:0];
          grant_d     = ONE_W << pick_ptr[CHANNELS-1:0];
          gnt_valid_d = 1'b1;
          cnt_d       = CNT_ONE;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          ptr_d = after_owner;
          if (pick_rel[CHANNELS]) begin
            select_d = pick_rel[CHANNELS-1:0];
            grant_d  = ONE_W << pick_rel[CHANNELS-1:0];
            cnt_d    = CNT_ONE;
          end else begin
            grant_d     = '0;
            gnt_valid_d = 1'b0;
            cnt_d       = '0;
          end
        end else if (cnt_q == BURST && others_req) begin
          // Forced rotation: owner is still requesting, so it is masked out of the pick.
          ptr_d     = after_owner;
          select_d  = pick_rot[CHANNELS-1:0];
          grant_d   = ONE_W << pick_rot[CHANNELS-1:0];
          cnt_d     = CNT_ONE;
          preempt_d = 1'b1;
        end else if (cnt_q != BURST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d     = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  assign grant     = grant_q;
  assign select    = select_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter
// Directed scenarios plus randomized traffic against a behavioural ownership model.
module tb_mux_rr_arbiter;
  localparam int W  = 32;
  localparam int C  = 5;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  req = '0;
  logic [W-1:0]  grant;
  logic [C-1:0]  select;
  logic          gnt_valid;
  logic          preempt;
  logic [W-1:0]  data = '0;
  logic          mux_out;

  int errors = 0;
  int checks = 0;

  int m_owner = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_sel = 0;
  bit m_pre = 0;

  mux_rr_arbiter #(.WIDTH(W), .CHANNELS(C), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .select(select), .gnt_valid(gnt_valid), .preempt(preempt)
  );

  assign mux_out = data[select];

  always #5 clk = ~clk;

  function automatic int m_pick(int start, logic [W-1:0] r);
    for (int k = 0; k < W; k++) begin
      int j;
      j = (start + k) % W;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] m_grant();
    logic [W-1:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic m_update(input logic [W-1:0] r, input logic rst);
    logic [W-1:0] others;
    m_pre = 0;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      if (r != 0) begin
        m_owner = m_pick(m_ptr, r); m_sel = m_owner; m_cnt = 1;
      end
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % W;
        m_owner = m_pick(m_ptr, r);
        if (m_owner >= 0) begin m_sel = m_owner; m_cnt = 1; end
        else m_cnt = 0;
      end else if (m_cnt == MB && others != 0) begin
        m_ptr = (m_owner + 1) % W;
        m_owner = m_pick(m_ptr, others); m_sel = m_owner; m_cnt = 1; m_pre = 1;
      end else if (m_cnt < MB) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step(input logic [W-1:0] r);
    req = r;
    @(posedge clk);
    m_update(r, reset);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step('0);
    step('0);
    reset = 1'b0;
    checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if (select !== '0) begin errors++; $display("FAIL reset_select got=%0d exp=0", select); end
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
    checks++; if (preempt !== 1'b0) begin errors++; $display("FAIL reset_preempt got=%b exp=0", preempt); end
  endtask

  task automatic test_reset_mid_burst();
    step(32'h4);
    step(32'h4);
    checks++; if (grant !== 32'h4) begin errors++; $display("FAIL midrst_pre got=%h exp=4", grant); end
    reset = 1'b1;
    step(32'h4);
    reset = 1'b0;
    checks++;
    if (grant !== '0 || gnt_valid !== 1'b0 || select !== '0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got=%h/%b/%0d/%b exp=0/0/0/0", grant, gnt_valid, select, preempt);
    end
    step(32'h2);
    checks++;
    if (grant !== 32'h2 || select !== 5'd1) begin
      errors++; $display("FAIL midrst_regrant got=%h/%0d exp=2/1", grant, select);
    end
    step('0);
  endtask

  task automatic test_single();
    for (int c = 1; c <= 20; c++) begin
      step(32'h10);
      checks++;
      if (grant !== 32'h10 || select !== 5'd4 || preempt !== 1'b0 || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_c%0d got=%h/%0d/%b exp=10/4/0", c, grant, select, preempt);
      end
    end
    step('0);
    checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL single_release got=%b exp=0", gnt_valid); end
  endtask

  task automatic test_rr_order();
    logic [W-1:0] reqs [9];
    logic [W-1:0] exps [9];
    reset = 1'b1; step('0); reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      reqs[c] = (c < 3) ? 32'h8000_0001 : (c < 6) ? 32'h8000_0000 : 32'h0000_0001;
      exps[c] = (c < 3) ? 32'h0000_0001 : (c < 6) ? 32'h8000_0000 : 32'h0000_0001;
    end
    for (int c = 0; c < 9; c++) begin
      step(reqs[c]);
      checks++;
      if (grant !== exps[c] || gnt_valid !== 1'b1) begin
        errors++; $display("FAIL rr_order_c%0d got=%h exp=%h", c, grant, exps[c]);
      end
    end
    step('0);
  endtask

  task automatic test_forced_rotation();
    logic [W-1:0] eg;
    bit           ep;
    reset = 1'b1; step('0); reset = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step(32'h3);
      eg = (((c - 1) / MB) % 2 == 1) ? 32'h2 : 32'h1;
      ep = (c > MB) && ((c - 1) % MB == 0);
      checks++;
      if (grant !== eg || preempt !== ep) begin
        errors++; $display("FAIL rotate_c%0d got=%h/%b exp=%h/%b", c, grant, preempt, eg, ep);
      end
    end
    step('0);
  endtask

  task automatic test_release_pending();
    reset = 1'b1; step('0); reset = 1'b0;
    step(32'h20);
    step(32'hA4);
    checks++; if (grant !== 32'h20) begin errors++; $display("FAIL pend_owner5 got=%h exp=20", grant); end
    step(32'h84);
    checks++;
    if (grant !== 32'h80 || preempt !== 1'b0) begin
      errors++; $display("FAIL pend_owner7 got=%h/%b exp=80/0", grant, preempt);
    end
    step(32'h04);
    checks++; if (grant !== 32'h04 || select !== 5'd2) begin errors++; $display("FAIL pend_owner2 got=%h/%0d exp=4/2", grant, select); end
    step('0);
  endtask

  task automatic test_random();
    logic [W-1:0] r, mask, eg;
    int           waits [W];
    int           bad;
    bad = 0;
    r = '0;
    mask = '1;
    for (int i = 0; i < W; i++) waits[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) mask = (c % 500 == 0) ? 32'hFFFF_FFFF : ($urandom & $urandom);
      for (int i = 0; i < W; i++) begin
        if (!r[i] && $urandom_range(0, 7) == 0) r[i] = 1'b1;
        else if (r[i] && $urandom_range(0, 23) == 0) r[i] = 1'b0;
      end
      r = r & mask;
      data = $urandom;
      step(r);
      eg = m_grant();
      checks++;
      if (grant !== eg || gnt_valid !== (m_owner >= 0) || select !== C'(m_sel) || preempt !== m_pre) begin
        errors++;
        $display("FAIL rand_model_c%0d got=%h/%b/%0d/%b exp=%h/%b/%0d/%b",
                 c, grant, gnt_valid, select, preempt, eg, (m_owner >= 0), m_sel, m_pre);
      end
      checks++;
      if (!$onehot0(grant) || gnt_valid !== (|grant) || (gnt_valid && grant[select] !== 1'b1)) begin
        errors++; $display("FAIL rand_invariant_c%0d got=%h/%b/%0d", c, grant, gnt_valid, select);
      end
      if (m_owner >= 0) begin
        checks++;
        if (mux_out !== data[m_owner]) begin
          errors++; $display("FAIL rand_mux_c%0d got=%b exp=%b", c, mux_out, data[m_owner]);
        end
      end
      for (int i = 0; i < W; i++) begin
        if (r[i] && !grant[i]) waits[i]++;
        else waits[i] = 0;
        if (waits[i] > (W - 1) * MB) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL rand_wait_c%0d got=%0d overdue exp=0", c, bad);
        bad = 0;
      end
    end
    step('0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_single();
    test_rr_order();
    test_forced_rotation();
    test_release_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
